// File: rtl/display_pkg.sv
// Shared types and constants for the product display: FSM states, seven-segment
// glyphs (active low, {g,f,e,d,c,b,a}) and the double-dabble nibble adjust.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Pre-shift correction so a BCD nibble stays decimal after doubling.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational glyph select for one display position: minus, blank or a BCD digit.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  input  logic       minus_i,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (minus_i) begin
      seg_c = SEG_MINUS;
    end else if (!blank_i) begin
      case (nibble_i)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/product_display.sv
// Captures a signed product, converts it to sign + BCD by shift-and-add-3, and
// scans the result onto an eight-digit common-anode seven-segment display.
module product_display
  import display_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned BCD_DIGITS  = 5,
  parameter int unsigned REFRESH_DIV = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           load,
  input  logic [2*N-1:0] product,
  output logic           busy,
  output logic [7:0]     an,
  output logic [6:0]     seg,
  output logic           dp
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned BW = 4 * BCD_DIGITS;
  localparam int unsigned CW = $clog2(PW + 1);
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_e          state_q, state_d;
  logic            sign_q, sign_d;
  logic [PW-1:0]   mag_q, mag_d;
  logic [BW-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            disp_sign_q, disp_sign_d;
  logic [BW-1:0]   disp_bcd_q, disp_bcd_d;

  logic [RW-1:0]   ref_q, ref_d;
  logic [2:0]      scan_q, scan_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q;
  logic [6:0]      seg_c;
  logic [3:0]      nib_sel;
  logic            blank_sel;
  logic            minus_sel;
  logic            nz_above;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control for the conversion.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    mag_d       = mag_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    disp_sign_d = disp_sign_q;
    disp_bcd_d  = disp_bcd_q;
    bcd_adj     = bcd_q;
    for (int k = 0; k < int'(BCD_DIGITS); k++) begin
      bcd_adj[4*k +: 4] = add3(bcd_q[4*k +: 4]);
    end
    case (state_q)
      IDLE: begin
        if (load) begin
          sign_d  = product[PW-1];
          mag_d   = product[PW-1] ? (~product + PW'(1)) : product;
          bcd_d   = '0;
          cnt_d   = CW'(PW);
          state_d = CONV;
        end
      end
      CONV: begin
        bcd_d = {bcd_adj[BW-2:0], mag_q[PW-1]};
        mag_d = {mag_q[PW-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_sign_d = sign_q;
        disp_bcd_d  = bcd_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sign_q      <= 1'b0;
      mag_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      disp_sign_q <= 1'b0;
      disp_bcd_q  <= '0;
    end else begin
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      disp_sign_q <= disp_sign_d;
      disp_bcd_q  <= disp_bcd_d;
    end
  end

  // Digit selection with leading-zero blanking; digit 0 always shows.
  always_comb begin
    nib_sel   = 4'd0;
    blank_sel = 1'b1;
    minus_sel = 1'b0;
    nz_above  = 1'b0;
    for (int i = int'(BCD_DIGITS) - 1; i >= 0; i--) begin
      nz_above = nz_above | (|disp_bcd_q[4*i +: 4]);
      if (3'(i) == scan_q) begin
        nib_sel   = disp_bcd_q[4*i +: 4];
        blank_sel = !nz_above && (i != 0);
      end
    end
    if (scan_q == 3'd7) begin
      minus_sel = disp_sign_q && (|disp_bcd_q);
      blank_sel = !minus_sel;
    end
  end

  seg7_decoder u_seg7_decoder (
    .nibble_i (nib_sel),
    .blank_i  (blank_sel),
    .minus_i  (minus_sel),
    .seg_c    (seg_c)
  );

  always_comb begin
    ref_d  = (ref_q == RW'(REFRESH_DIV - 1)) ? '0 : ref_q + RW'(1);
    scan_d = (ref_q == RW'(REFRESH_DIV - 1)) ? scan_q + 3'd1 : scan_q;
    an_d   = ~(8'd1 << scan_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_q  <= '0;
      scan_q <= '0;
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
    end else begin
      ref_q  <= ref_d;
      scan_q <= scan_d;
      an_q   <= an_d;
      seg_q  <= seg_c;
    end
  end

  assign busy = busy_q;
  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;

endmodule
